// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU, the result FIFO and the writeback consumer.
// slave is the FIFO side; master is the upstream/consumer side that drives it.
interface alu_result_fifo_if #(
  parameter int NUMBITS = 16,
  parameter int CNTBITS = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
  logic               overflow;
  logic               zero;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] out_result;
  logic               out_carry;
  logic               out_overflow;
  logic               out_zero;
  logic [2:0]         out_opcode;
  logic [CNTBITS-1:0] count;
  logic               clear_sticky;
  logic               sticky_ovf;
  logic               sticky_carry;

  modport master (
    output in_valid, result, carryout, overflow, zero, opcode, out_ready, clear_sticky,
    input  in_ready, out_valid, out_result, out_carry, out_overflow, out_zero, out_opcode,
           count, sticky_ovf, sticky_carry
  );

  modport slave (
    input  in_valid, result, carryout, overflow, zero, opcode, out_ready, clear_sticky,
    output in_ready, out_valid, out_result, out_carry, out_overflow, out_zero, out_opcode,
           count, sticky_ovf, sticky_carry
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO capturing ALU results with their flags and opcode, plus sticky
// signed-overflow / unsigned-carry status for exception reporting.
module alu_result_fifo #(
  parameter int NUMBITS = 16,
  parameter int DEPTH   = 4,
  parameter int CNTBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  alu_result_fifo_if.slave bus
);
  localparam int PTRBITS   = $clog2(DEPTH);
  localparam int ENTRYBITS = NUMBITS + 6;

  logic [ENTRYBITS-1:0] mem [DEPTH];
  logic [PTRBITS-1:0]   wr_ptr_reg;
  logic [PTRBITS-1:0]   rd_ptr_reg;
  logic [CNTBITS-1:0]   count_reg;
  logic                 sticky_ovf_reg;
  logic                 sticky_carry_reg;

  logic                 push;
  logic                 pop;
  logic                 set_ovf;
  logic                 set_carry;
  logic                 sticky_ovf_next;
  logic                 sticky_carry_next;
  logic [ENTRYBITS-1:0] head;

  assign bus.in_ready  = (count_reg != CNTBITS'(DEPTH));
  assign bus.out_valid = (count_reg != '0);

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Only signed ops report overflow and only unsigned ops report carry.
  assign set_ovf   = push & bus.overflow &
                     ((bus.opcode == 3'b001) | (bus.opcode == 3'b011));
  assign set_carry = push & bus.carryout &
                     ((bus.opcode == 3'b000) | (bus.opcode == 3'b010));

  assign sticky_ovf_next   = set_ovf   | (sticky_ovf_reg   & ~bus.clear_sticky);
  assign sticky_carry_next = set_carry | (sticky_carry_reg & ~bus.clear_sticky);

  // Storage carries no reset; empty slots are masked at the output instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.opcode, bus.zero, bus.overflow, bus.carryout, bus.result};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      sticky_ovf_reg   <= 1'b0;
      sticky_carry_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTRBITS'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTRBITS'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNTBITS'(1);
        2'b01:   count_reg <= count_reg - CNTBITS'(1);
        default: count_reg <= count_reg;
      endcase
      sticky_ovf_reg   <= sticky_ovf_next;
      sticky_carry_reg <= sticky_carry_next;
    end
  end

  assign head = bus.out_valid ? mem[rd_ptr_reg] : '0;

  assign {bus.out_opcode, bus.out_zero, bus.out_overflow, bus.out_carry, bus.out_result} = head;

  assign bus.count        = count_reg;
  assign bus.sticky_ovf   = sticky_ovf_reg;
  assign bus.sticky_carry = sticky_carry_reg;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench: hand-derived vector table, randomized traffic against a
// queue-based reference model, and an asynchronous mid-cycle reset sequence.
module tb_alu_result_fifo;
  localparam int NUMBITS = 16;
  localparam int DEPTH   = 4;
  localparam int CNTBITS = 3;

  logic clk;
  logic reset;

  alu_result_fifo_if #(.NUMBITS(NUMBITS), .CNTBITS(CNTBITS)) bus ();

  alu_result_fifo #(.NUMBITS(NUMBITS), .DEPTH(DEPTH), .CNTBITS(CNTBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic        z;
    logic        o;
    logic        c;
    logic [15:0] res;
  } entry_t;

  typedef struct {
    bit        iv;
    bit        ordy;
    bit        clr;
    bit [15:0] res;
    bit [2:0]  op;
    bit        c;
    bit        o;
    bit        z;
    int        e_cnt;
    bit        e_ov;
    bit        e_ir;
    bit [15:0] e_res;
    bit        e_so;
    bit        e_sc;
  } vec_t;

  vec_t   vecs[$];
  entry_t q[$];
  bit     m_so;
  bit     m_sc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit clr, input bit [15:0] res,
                       input bit [2:0] op, input bit c, input bit o, input bit z);
    bus.in_valid     = iv;
    bus.out_ready    = ordy;
    bus.clear_sticky = clr;
    bus.result       = res;
    bus.opcode       = op;
    bus.carryout     = c;
    bus.overflow     = o;
    bus.zero         = z;
  endtask

  function automatic vec_t mk(bit iv, bit ordy, bit clr, bit [15:0] res, bit [2:0] op,
                              bit c, bit o, bit z, int e_cnt, bit e_ov, bit e_ir,
                              bit [15:0] e_res, bit e_so, bit e_sc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.clr = clr; v.res = res; v.op = op;
    v.c = c; v.o = o; v.z = z; v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir;
    v.e_res = e_res; v.e_so = e_so; v.e_sc = e_sc;
    return v;
  endfunction

  // Reference model: one accepted transaction applied to a plain queue.
  task automatic model_step(input bit iv, input bit ordy, input bit clr, input entry_t e,
                            output bit did_push, output bit did_pop);
    did_push = iv && (q.size() < DEPTH);
    did_pop  = ordy && (q.size() != 0);
    if (did_pop) void'(q.pop_front());
    if (did_push) q.push_back(e);
    if (did_push && e.o && (e.op == 3'd1 || e.op == 3'd3)) m_so = 1'b1;
    else if (clr) m_so = 1'b0;
    if (did_push && e.c && (e.op == 3'd0 || e.op == 3'd2)) m_sc = 1'b1;
    else if (clr) m_sc = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    entry_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, " count"},     32'(bus.count),        32'(q.size()));
    chk({tag, " in_ready"},  32'(bus.in_ready),     32'(q.size() != DEPTH));
    chk({tag, " out_valid"}, 32'(bus.out_valid),    32'(q.size() != 0));
    chk({tag, " out_res"},   32'(bus.out_result),   32'(h.res));
    chk({tag, " out_op"},    32'(bus.out_opcode),   32'(h.op));
    chk({tag, " out_flags"}, 32'({bus.out_zero, bus.out_overflow, bus.out_carry}),
        32'({h.z, h.o, h.c}));
    chk({tag, " sticky_ovf"},   32'(bus.sticky_ovf),   32'(m_so));
    chk({tag, " sticky_carry"}, 32'(bus.sticky_carry), 32'(m_sc));
  endtask

  initial begin
    bit     p;
    bit     pp;
    entry_t e;

    // Fill queue, wrap, full-with-pop, drain; then sticky behaviour.
    vecs.push_back(mk(1, 0, 0, 16'h1234, 3'b000, 0, 0, 0, 1, 1, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 3'b000, 0, 0, 0, 1, 1, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 3'b000, 0, 0, 0, 1, 1, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 3'b000, 0, 0, 0, 1, 1, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0002, 3'b000, 0, 0, 0, 2, 1, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0003, 3'b000, 0, 0, 0, 3, 1, 1, 16'h1234, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0004, 3'b000, 0, 0, 0, 4, 1, 0, 16'h1234, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0005, 3'b000, 0, 0, 0, 4, 1, 0, 16'h1234, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 3'b000, 0, 0, 0, 3, 1, 1, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0006, 3'b000, 0, 0, 0, 3, 1, 1, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0007, 3'b000, 0, 0, 0, 4, 1, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0008, 3'b000, 0, 0, 0, 3, 1, 1, 16'h0004, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0008, 3'b000, 0, 0, 0, 3, 1, 1, 16'h0006, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 3'b000, 0, 0, 0, 2, 1, 1, 16'h0007, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 3'b000, 0, 0, 0, 1, 1, 1, 16'h0008, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h8000, 3'b001, 0, 1, 0, 1, 1, 1, 16'h8000, 1, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 3'b000, 1, 0, 1, 1, 1, 1, 16'h0000, 1, 1));
    vecs.push_back(mk(1, 1, 0, 16'h1111, 3'b101, 1, 1, 0, 1, 1, 1, 16'h1111, 1, 1));
    vecs.push_back(mk(1, 1, 1, 16'h2222, 3'b011, 0, 1, 0, 1, 1, 1, 16'h2222, 1, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 3'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset count",        32'(bus.count),        32'd0);
    chk("reset out_valid",    32'(bus.out_valid),    32'd0);
    chk("reset in_ready",     32'(bus.in_ready),     32'd1);
    chk("reset out_result",   32'(bus.out_result),   32'd0);
    chk("reset sticky_ovf",   32'(bus.sticky_ovf),   32'd0);
    chk("reset sticky_carry", 32'(bus.sticky_carry), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].res, vecs[i].op,
            vecs[i].c, vecs[i].o, vecs[i].z);
      cycle();
      $display("vec %0d: iv=%0b ordy=%0b clr=%0b res=%h op=%0d -> count=%0d out=%h",
               i, vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].res, vecs[i].op,
               bus.count, bus.out_result);
      chk($sformatf("vec%0d count", i),        32'(bus.count),        32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d out_valid", i),    32'(bus.out_valid),    32'(vecs[i].e_ov));
      chk($sformatf("vec%0d in_ready", i),     32'(bus.in_ready),     32'(vecs[i].e_ir));
      chk($sformatf("vec%0d out_result", i),   32'(bus.out_result),   32'(vecs[i].e_res));
      chk($sformatf("vec%0d sticky_ovf", i),   32'(bus.sticky_ovf),   32'(vecs[i].e_so));
      chk($sformatf("vec%0d sticky_carry", i), 32'(bus.sticky_carry), 32'(vecs[i].e_sc));
    end

    // Randomized traffic from a clean state against the queue model.
    drive(0, 0, 0, 16'h0, 3'b0, 0, 0, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    q.delete();
    m_so = 1'b0;
    m_sc = 1'b0;
    for (int n = 0; n < 200; n++) begin
      e.res = 16'($urandom);
      e.op  = 3'($urandom_range(0, 7));
      e.c   = 1'($urandom);
      e.o   = 1'($urandom);
      e.z   = (e.res == 16'h0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), e.res, e.op, e.c, e.o, e.z);
      model_step(bus.in_valid, bus.out_ready, bus.clear_sticky, e, p, pp);
      cycle();
      $display("rnd %0d: push=%0b pop=%0b res=%h op=%0d count=%0d", n, p, pp, e.res, e.op,
               bus.count);
      compare_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-cycle with three entries buffered.
    drive(0, 0, 0, 16'h0, 3'b0, 0, 0, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1, 0, 0, 16'h7001, 3'b001, 0, 1, 0); cycle();
    drive(1, 0, 0, 16'h7002, 3'b000, 1, 0, 0); cycle();
    drive(1, 0, 0, 16'h7003, 3'b010, 0, 0, 0); cycle();
    drive(0, 0, 0, 16'h0, 3'b0, 0, 0, 0);
    $display("pre-reset: count=%0d sticky_ovf=%0b sticky_carry=%0b", bus.count,
             bus.sticky_ovf, bus.sticky_carry);
    chk("pre-reset count",        32'(bus.count),        32'd3);
    chk("pre-reset sticky_ovf",   32'(bus.sticky_ovf),   32'd1);
    chk("pre-reset sticky_carry", 32'(bus.sticky_carry), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    $display("async reset: count=%0d out_valid=%0b in_ready=%0b", bus.count, bus.out_valid,
             bus.in_ready);
    chk("async count",        32'(bus.count),        32'd0);
    chk("async out_valid",    32'(bus.out_valid),    32'd0);
    chk("async in_ready",     32'(bus.in_ready),     32'd1);
    chk("async out_result",   32'(bus.out_result),   32'd0);
    chk("async sticky_ovf",   32'(bus.sticky_ovf),   32'd0);
    chk("async sticky_carry", 32'(bus.sticky_carry), 32'd0);
    #2;
    reset = 1'b0;

    // First push after reset: visible on the next cycle only.
    drive(1, 0, 0, 16'hBEEF, 3'b010, 1, 0, 0);
    #1;
    chk("no bypass out_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    drive(0, 0, 0, 16'h0, 3'b0, 0, 0, 0);
    $display("post-reset push: count=%0d out=%h", bus.count, bus.out_result);
    chk("post-reset count",        32'(bus.count),        32'd1);
    chk("post-reset out_result",   32'(bus.out_result),   32'h0000BEEF);
    chk("post-reset out_opcode",   32'(bus.out_opcode),   32'd2);
    chk("post-reset sticky_carry", 32'(bus.sticky_carry), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream capture stage for the 16-bit ALU.
- Accepts each ALU result together with its flags (carryout, overflow, zero) and the opcode that produced it, using a valid/ready handshake.
- Buffers entries in a small show-ahead FIFO for the writeback/consumer stage.
- Keeps sticky signed-overflow and unsigned-carry status bits for software-visible exception reporting.

Parameters:
- NUMBITS, 16, width of result datapath; matches ALU width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNTBITS, 3, width of occupancy count; must satisfy 2^CNTBITS > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream ALU entry valid this cycle.
- in_ready  output  1  FIFO can accept an entry this cycle.
- result  input  NUMBITS  ALU result.
- carryout  input  1  ALU carry/borrow out.
- overflow  input  1  ALU signed overflow.
- zero  input  1  ALU zero flag.
- opcode  input  3  ALU opcode (000 add, 001 signed add, 010 sub, 011 signed sub; others reserved).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_result  output  NUMBITS  head result.
- out_carry  output  1  head carryout.
- out_overflow  output  1  head overflow.
- out_zero  output  1  head zero.
- out_opcode  output  3  head opcode.
- count  output  CNTBITS  current occupancy, 0..DEPTH.
- clear_sticky  input  1  synchronous clear of sticky flags.
- sticky_ovf  output  1  a signed op with overflow=1 was accepted since last clear.
- sticky_carry  output  1  an unsigned op with carryout=1 was accepted since last clear.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, sticky_ovf=0, sticky_carry=0. All out_* data fields read 0. Storage array is not reset.
- Reset asserted mid-operation flushes all entries immediately; buffered data is lost.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on state, never combinationally on out_ready.
- out_valid = (count != 0).
- Show-ahead: out_* present the entry at rd_ptr combinationally from storage. When count==0, out_* are forced to 0.
- Latency: an entry pushed into an empty FIFO appears on out_* with out_valid=1 on the next cycle. There is no same-cycle bypass.
- Entry format: {opcode, zero, overflow, carryout, result}, stored unmodified. The block does not recompute or mask flags.
- Pointers advance by 1 on push (wr_ptr) or pop (rd_ptr) and wrap modulo DEPTH (DEPTH-1 -> 0).
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Full (count==DEPTH): in_ready=0, no push. A pop in the same cycle frees a slot, but that slot is first usable on the following cycle.
- Empty (count==0): pop is impossible because out_valid=0. A push in that cycle is accepted.
- in_valid while in_ready=0: entry is not captured. Upstream must hold it; no error flag is raised.
- Sticky flags, updated only on an accepted push:
  - sticky_ovf sets if opcode is 001 or 011 and overflow=1.
  - sticky_carry sets if opcode is 000 or 010 and carryout=1.
  - Reserved opcodes never set either flag.
- clear_sticky: both stickies go to 0 on the next edge. If a set condition occurs in the same cycle, set wins (flag ends at 1).
- Registered outputs: count, sticky_ovf, sticky_carry. Derived combinationally from registered state: in_ready, out_valid, out_*.

Test Plan:
- Reset then single push (result=0x1234, opcode=000, carry=0) with out_ready=0 -> next cycle out_valid=1, out_result=0x1234, count=1; hold 3 cycles -> outputs stable.
- Push 4 entries (0x0001..0x0004) with out_ready=0 -> count=4, in_ready=0. A 5th in_valid (0x0005) is not captured. Set out_ready=1 for 4 cycles -> pops 0x0001..0x0004 in order; count returns to 0; out_* = 0.
- Full FIFO with in_valid=1 and out_ready=1 for one cycle -> pop occurs, push does not, count=3. Next cycle push is accepted, count=4. Pointers wrap: after 6 total pushes and pops, order is still preserved.
- Steady stream with in_valid=1 and out_ready=1 starting from count=1 -> count stays 1 every cycle, one entry per cycle, no loss.
- Push opcode=001, overflow=1 (0x7FFF+0x0001=0x8000) -> sticky_ovf=1, sticky_carry=0. Push opcode=000, carryout=1 (0xFFFF+0x0001) -> sticky_carry=1. Push opcode=101, overflow=1 -> no change. clear_sticky in the same cycle as a push with opcode=011, overflow=1 -> sticky_ovf=1, sticky_carry=0.
- Push 3 entries, then assert reset asynchronously mid-cycle -> count=0, out_valid=0, in_ready=1, stickies 0 immediately, before the next edge.
